instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Instruction fetch front end for the 9-bit-instruction core. It owns the program counter, drives the address into the combinational instruction ROM, and captures the returned machine code into a registered output slot. Decode consumes that slot through a valid/ready handshake. The block also accepts branch redirects (absolute or PC-relative) and a halt request from execute, and reports program completion.

Parameters:
D, 12, instruction address width (ROM depth 2**D)
W, 9, instruction word width
START_ADDR, 0, PC value loaded on reset and on start

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin fetching at START_ADDR (honoured in IDLE or HALTED only)
rom_address  out  D  address to instruction ROM; combinational copy of pc
rom_machine_code  in  W  ROM data; combinational function of rom_address, same cycle
instr  out  W  registered instruction for decode
instr_pc  out  D  address instr was fetched from
instr_valid  out  1  instr/instr_pc hold a live instruction
instr_ready  in  1  decode accepts instr this cycle
branch_en  in  1  redirect request, sampled only in FETCH
branch_rel  in  1  1: target = instr_pc + sign-extended branch_target; 0: target = branch_target
branch_target  in  D  absolute address or two's-complement offset
halt  in  1  stop fetching, sampled only in FETCH
busy  out  1  high in FETCH
done  out  1  high in HALTED

Behaviour:
- States: IDLE, FETCH, HALTED. State and output signals are registered; rom_address = pc (combinational).
- Reset takes priority over every other input, including mid-FETCH. Reset values: state=IDLE, pc=START_ADDR, instr=0, instr_pc=0, instr_valid=0, busy=0, done=0.
- IDLE or HALTED with start=1: pc<=START_ADDR, instr_valid<=0, done<=0, next state FETCH. start is ignored in FETCH.
- Slot load condition in FETCH: load = !instr_valid || instr_ready.
- FETCH priority, highest first:
  1. halt=1: state<=HALTED, instr_valid<=0, pc unchanged. Halt beats a simultaneous branch and drops any unconsumed instruction.
  2. branch_en=1: pc<=target, instr_valid<=0. This flushes the slot regardless of instr_ready and does not load this cycle, giving exactly one bubble. The relative target uses the current instr_pc.
  3. load: instr<=rom_machine_code, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
  4. Otherwise (valid && !ready) is a stall: instr, instr_pc, instr_valid and pc all hold.
- Arithmetic: pc+1 and relative targets are computed modulo 2**D. After 2**D-1 the PC wraps to 0. There is no overflow flag.
- Latency:
  - start at edge N gives FETCH from edge N+1.
  - The first instruction (core[START_ADDR]) is valid after edge N+2.
  - Sustained throughput is 1 instruction/cycle while instr_ready=1.
- A handshake completes on any cycle with instr_valid && instr_ready. Each ROM word is delivered exactly once per sequential pass; there are no duplicates or skips across stalls.
- Outside FETCH, instr_valid=0, and branch_en/halt are ignored.
- busy and done are mutually exclusive. Both are 0 in IDLE.

Test Plan:
1. Reset, then pulse start with ROM[0..3]=9'h07E,9'h066,9'h07A,9'h1DE and instr_ready=1 -> instr_valid rises 2 cycles after start; instr/instr_pc sequence is 07E/0, 066/1, 07A/2, 1DE/3 on consecutive cycles.
2. Stall: drop instr_ready for 3 cycles while instr=066 at pc 1 -> instr, instr_pc=1 and rom_address=2 hold for 3 cycles; the next accepted word is 07A at pc 2, with no skip or duplicate.
3. Absolute branch: branch_en=1, branch_rel=0, branch_target=12'h100 while instr_pc=2 -> next cycle instr_valid=0 (one bubble); the following cycle instr=ROM[0x100], instr_pc=0x100.
4. Relative branch backwards: instr_pc=5, branch_rel=1, branch_target=12'hFFD (-3) -> the next delivered instr_pc is 2. Also instr_pc=0, offset -1 -> instr_pc=0xFFF (wrap).
5. halt and branch_en asserted together in FETCH -> HALTED next cycle, done=1, busy=0, instr_valid=0; a later start restarts at START_ADDR with done cleared.
6. Assert reset mid-FETCH with instr_valid=1 and instr_ready=0 -> next cycle all outputs at reset values, state IDLE; start, halt and branch_en asserted in that same cycle are ignored.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, addresses the combinational ROM and holds one
// registered instruction slot handed to decode over a valid/ready handshake.
module instruction_fetch #(
  parameter int unsigned D          = 12,
  parameter int unsigned W          = 9,
  parameter int unsigned START_ADDR = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [D-1:0] rom_address,
  input  logic [W-1:0] rom_machine_code,
  output logic [W-1:0] instr,
  output logic [D-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         branch_en,
  input  logic         branch_rel,
  input  logic [D-1:0] branch_target,
  input  logic         halt,
  output logic         busy,
  output logic         done
);

  localparam logic [D-1:0] StartPc = D'(START_ADDR);

  typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

  state_e         state_q;
  logic [D-1:0]   pc_q;
  logic [D-1:0]   instr_pc_q;
  logic [W-1:0]   instr_q;
  logic           valid_q;
  logic           busy_q;
  logic           done_q;

  logic [D-1:0]   target;
  logic           load;

  // Relative targets add a two's-complement offset; D-bit arithmetic gives the wrap for free.
  always_comb begin
    target = branch_rel ? (instr_pc_q + branch_target) : branch_target;
    load   = !valid_q || instr_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= StartPc;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StHalted: begin
          if (start) begin
            state_q <= StFetch;
            pc_q    <= StartPc;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StFetch: begin
          if (halt) begin
            state_q <= StHalted;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (branch_en) begin
            // Redirect flushes the slot and skips the load, leaving one bubble.
            pc_q    <= target;
            valid_q <= 1'b0;
          end else if (load) begin
            instr_q    <= rom_machine_code;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= pc_q + D'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_address = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a per-cycle behavioural model predicts the
// delivered instruction stream and status outputs; a negedge monitor checks the DUT.
module tb_instruction_fetch;

  localparam int D = 12;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset, start, instr_ready, branch_en, branch_rel, halt;
  logic [D-1:0] branch_target, rom_address, instr_pc;
  logic [W-1:0] rom_machine_code, instr;
  logic         instr_valid, busy, done;

  logic [W-1:0] rom [1<<D];

  always #5 clk = ~clk;

  assign rom_machine_code = rom[rom_address];

  instruction_fetch #(.D(D), .W(W), .START_ADDR(0)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .rom_address      (rom_address),
    .rom_machine_code (rom_machine_code),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .branch_en        (branch_en),
    .branch_rel       (branch_rel),
    .branch_target    (branch_target),
    .halt             (halt),
    .busy             (busy),
    .done             (done)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // Model: 0 = idle, 1 = fetching, 2 = halted.
  int           m_state;
  logic [D-1:0] m_pc, m_ipc;
  logic [W-1:0] m_instr;
  logic         m_valid;

  logic [W+D-1:0] sb_q[$];

  task automatic cyc(input logic rst, input logic st, input logic hl, input logic be,
                     input logic rel, input logic [D-1:0] tgt, input logic rdy);
    int           n_state;
    logic [D-1:0] n_pc, n_ipc;
    logic [W-1:0] n_instr;
    logic         n_valid;
    reset = rst; start = st; halt = hl; branch_en = be; branch_rel = rel;
    branch_target = tgt; instr_ready = rdy;
    if (m_valid && rdy) sb_q.push_back({m_instr, m_ipc});
    n_state = m_state; n_pc = m_pc; n_ipc = m_ipc; n_instr = m_instr; n_valid = m_valid;
    if (rst) begin
      n_state = 0; n_pc = '0; n_ipc = '0; n_instr = '0; n_valid = 1'b0;
    end else if (m_state != 1) begin
      if (st) begin
        n_state = 1; n_pc = '0; n_valid = 1'b0;
      end
    end else if (hl) begin
      n_state = 2; n_valid = 1'b0;
    end else if (be) begin
      n_pc = rel ? D'((int'(m_ipc) + int'(tgt)) % (1 << D)) : tgt;
      n_valid = 1'b0;
    end else if (!m_valid || rdy) begin
      n_instr = rom[m_pc]; n_ipc = m_pc; n_valid = 1'b1;
      n_pc = D'((int'(m_pc) + 1) % (1 << D));
    end
    @(posedge clk);
    #2;
    m_state = n_state; m_pc = n_pc; m_ipc = n_ipc; m_instr = n_instr; m_valid = n_valid;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, rdy);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [W+D-1:0] exp;
      checks++;
      if ({busy, done, instr_valid, rom_address} !==
          {(m_state == 1), (m_state == 2), m_valid, m_pc}) begin
        errors++;
        $display("FAIL status: busy/done/valid/addr got %b/%b/%b/%h want %b/%b/%b/%h",
                 busy, done, instr_valid, rom_address,
                 (m_state == 1), (m_state == 2), m_valid, m_pc);
      end
      checks++;
      if ({instr, instr_pc} !== {m_instr, m_ipc}) begin
        errors++;
        $display("FAIL slot: instr/pc got %h/%h want %h/%h", instr, instr_pc, m_instr, m_ipc);
      end
      if (instr_valid && instr_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL handshake: got %h/%h want no transfer", instr, instr_pc);
        end else begin
          exp = sb_q.pop_front();
          if ({instr, instr_pc} !== exp) begin
            errors++;
            $display("FAIL handshake: got %h/%h want %h/%h", instr, instr_pc,
                     exp[W+D-1:D], exp[D-1:0]);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << D); i++) rom[i] = W'($urandom);
    rom[0] = 9'h07E; rom[1] = 9'h066; rom[2] = 9'h07A; rom[3] = 9'h1DE;
    m_state = 0; m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 1'b0;

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    mon_en = 1'b1;
    idle(1'b0);

    // Straight-line fetch after start.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Stall with 066 at pc 1, then absolute branch while instr_pc = 2.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h100, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Relative branch back by 3 from instr_pc 5.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFD, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Relative -1 from instr_pc 0 wraps to 0xFFF, then on to 0x000.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Halt together with branch, then restart.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h200, 1'b0);
    idle(1'b1);
    idle(1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Reset mid-fetch while stalled, with start/halt/branch also asserted.
    idle(1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h055, 1'b0);
    idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
          1'($urandom), D'($urandom), ($urandom_range(0, 9) < 7));
    end
    idle(1'b0);
    @(negedge clk);
    #1;

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending transfers got %0d want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
